block_sram: RTL and testbench
=============================

Name: block_sram

Overview:
- Parametrised successor to the byte-addressed key/data store in the I2C Triple-DES datapath.
- Holds DEPTH words of DATA_W bits, addressed from BASE_ADDR, with registered reads and per-word valid tracking.
- Exposes the whole array in parallel, with a "block full" flag, so the DES core can load a complete key or data block at once.
- Adds a sequential clear sweep and out-of-range error reporting.

Parameters:
- DATA_W, 8, word width in bits.
- DEPTH, 8, number of words (must be at least 2).
- ADDR_W, 16, width of the address bus.
- BASE_ADDR, 1, bus address of word 0; valid addresses are BASE_ADDR to BASE_ADDR+DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- read_enable  input  1  read request, sampled each cycle.
- write_enable  input  1  write request, sampled each cycle.
- address  input  ADDR_W  bus address.
- write_data  input  DATA_W  write data.
- clear  input  1  single-cycle request to start the clear sweep.
- read_data  output  DATA_W  registered read data.
- read_valid  output  1  one-cycle pulse; read_data was updated this cycle.
- addr_err  output  1  one-cycle pulse; the previous request was out of range.
- block_data  output  DATA_W*DEPTH  whole array; word i sits at [i*DATA_W +: DATA_W].
- block_full  output  1  high when every word has been written since the last reset or clear.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (async, n_rst=0): all words, the valid bitmap, read_data, read_valid, addr_err, busy and block_full go to 0. The FSM goes to IDLE and the sweep counter to 0.
- Index: idx = address - BASE_ADDR. The request is in range iff BASE_ADDR <= address <= BASE_ADDR+DEPTH-1; compare at full ADDR_W width with no wrap.
- Write (IDLE, write_enable=1, in range): at the clock edge, mem[idx] <= write_data and valid[idx] <= 1. The new value appears on block_data the next cycle.
- Read (IDLE, read_enable=1, in range): on the next edge, read_data <= mem[idx] and read_valid=1 for one cycle. Read latency is 1 cycle. Otherwise read_data holds its last value and read_valid=0.
- Read and write in the same cycle:
  - Different addresses: both are performed.
  - Same address: the read returns the old contents (unless the bypass macro below is defined).
- Out of range (IDLE, either enable=1): addr_err=1 on the next cycle for one cycle. Memory, valid bits and read_data are unchanged, and read_valid=0.
- block_full is the AND of the valid bitmap, driven straight from registers (no extra latency beyond the bitmap update).
- FSM states: IDLE and CLEAR.
  - IDLE to CLEAR when clear=1. The counter is loaded with 0 and busy=1 from the next cycle.
  - In CLEAR, each cycle mem[cnt] <= 0, valid[cnt] <= 0 and cnt increments.
  - After word DEPTH-1 is cleared, return to IDLE with busy=0. busy is high for exactly DEPTH cycles.
- In CLEAR, read_enable, write_enable and clear are ignored: no read_valid, no addr_err, no state change.
- clear together with a write or read in IDLE: clear wins and the access is dropped, with no read_valid and no addr_err.
- Reset during CLEAR aborts the sweep: everything is zeroed and the FSM returns to IDLE.
- The sweep counter is $clog2(DEPTH) bits and must not wrap past DEPTH-1.

Optional Feature:
- Macro: BLOCK_SRAM_RD_BYPASS_EN.
- Defined: a same-cycle read and write to the same in-range address returns write_data on read_data the next cycle (write-through forwarding).
- Not defined: that read returns the pre-write contents.
- All other behaviour is identical either way.

Test Plan (defaults: DATA_W=8, DEPTH=8, BASE_ADDR=1):
- Reset, then write 8'hA5 to address 16'h0003, then read 16'h0003 -> one cycle later read_data=8'hA5, read_valid=1 for exactly one cycle, and block_data[23:16]=8'hA5.
- Write addresses 1 through 8 with data 8'h11 through 8'h88 -> block_full stays 0 until the cycle after the eighth write, then 1; block_data=64'h8877665544332211.
- Read 16'h0000, then write 16'h0009 -> addr_err pulses once for each request; memory unchanged; read_valid=0.
- Full array, then pulse clear -> busy=1 for exactly 8 cycles and a write during the sweep is ignored. Afterwards block_data=0 and block_full=0, and reading 16'h0005 returns 8'h00.
- Address 16'h0004 holds 8'h3C; in one cycle write 8'hC3 and read 16'h0004 -> read_data=8'h3C without the macro, 8'hC3 with BLOCK_SRAM_RD_BYPASS_EN.
- Assert n_rst low at the fourth sweep cycle -> all outputs 0 and busy=0; the next write and read of 16'h0002 completes normally.

Source files
------------

// File: rtl/block_sram.sv
// Parametrised word store with 1-cycle registered reads, per-word valid bits, a parallel block view and a sequential clear sweep.
// Latency: read_data/read_valid/addr_err one cycle after the request; block_data/block_full one cycle after a write.
// Backpressure: none; requests are dropped while busy, and BLOCK_SRAM_RD_BYPASS_EN forwards same-cycle write data to the read.
module block_sram #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    read_enable,
  input  logic                    write_enable,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       write_data,
  input  logic                    clear,
  output logic [DATA_W-1:0]       read_data,
  output logic                    read_valid,
  output logic                    addr_err,
  output logic [DATA_W*DEPTH-1:0] block_data,
  output logic                    block_full,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int AW1   = ADDR_W + 1;

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;
  logic [DEPTH-1:0]               valid_q, valid_d;
  logic [DATA_W-1:0]              read_data_q, read_data_d;
  logic                           read_valid_q, read_valid_d;
  logic                           addr_err_q, addr_err_d;
  logic                           busy_q, busy_d;

  logic [DEPTH-1:0]               hit;
  logic                           in_range;
  logic [DATA_W-1:0]              rd_word;

  // Range check is a per-word equality against the widened address, so no
  // subtraction can wrap and out-of-range simply means no word matched.
  always_comb begin
    hit     = '0;
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, address} == AW1'(BASE_ADDR + i)) begin
        hit[i]  = 1'b1;
        rd_word = mem_q[i];
      end
    end
    in_range = |hit;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_d        = mem_q;
    valid_d      = valid_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          addr_err_d = (read_enable | write_enable) & ~in_range;
          if (read_enable && in_range) begin
            read_valid_d = 1'b1;
`ifdef BLOCK_SRAM_RD_BYPASS_EN
            read_data_d  = write_enable ? write_data : rd_word;
`else
            read_data_d  = rd_word;
`endif
          end
          if (write_enable && in_range) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (hit[i]) begin
                mem_d[i]   = write_data;
                valid_d[i] = 1'b1;
              end
            end
          end
        end
      end
      S_CLEAR: begin
        mem_d[cnt_q]   = '0;
        valid_d[cnt_q] = 1'b0;
        // Leave on the last word so the counter never runs past DEPTH-1.
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_q        <= '0;
      valid_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      valid_q      <= valid_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
      busy_q       <= busy_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = busy_q;
  assign block_data = mem_q;
  assign block_full = &valid_q;

endmodule

// File: tb/tb_block_sram.sv
// Directed bench for block_sram with a spec-level reference model checked every cycle.
module tb_block_sram;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;
  localparam int BASE   = 1;
`ifdef BLOCK_SRAM_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              read_enable = 1'b0;
  logic              write_enable = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              addr_err;
  logic [63:0]       block_data;
  logic              block_full;
  logic              busy;

  block_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .n_rst(n_rst), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .clear(clear), .read_data(read_data),
    .read_valid(read_valid), .addr_err(addr_err), .block_data(block_data),
    .block_full(block_full), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: words as an array, sweep as a count of words still to clear.
  logic [7:0] m_mem [DEPTH];
  bit         m_val [DEPTH];
  logic [7:0] m_rd = '0;
  bit         m_rv = 1'b0;
  bit         m_err = 1'b0;
  int         m_left = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
      m_rd = '0; m_rv = 1'b0; m_err = 1'b0; m_left = 0;
    end else begin
      int a;
      bit inr;
      a = int'(address);
      inr = (a >= BASE) && (a < BASE + DEPTH);
      m_rv = 1'b0;
      m_err = 1'b0;
      if (m_left > 0) begin
        m_mem[DEPTH - m_left] = '0;
        m_val[DEPTH - m_left] = 1'b0;
        m_left--;
      end else if (clear) begin
        m_left = DEPTH;
      end else begin
        if ((read_enable || write_enable) && !inr) m_err = 1'b1;
        if (read_enable && inr) begin
          m_rd = (BYP && write_enable) ? write_data : m_mem[a - BASE];
          m_rv = 1'b1;
        end
        if (write_enable && inr) begin
          m_mem[a - BASE] = write_data;
          m_val[a - BASE] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] exp_blk;
      bit          exp_full;
      exp_full = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        exp_blk[i*8 +: 8] = m_mem[i];
        exp_full = exp_full & m_val[i];
      end
      chk("model_read_data", 64'(read_data), 64'(m_rd));
      chk("model_read_valid", 64'(read_valid), 64'(m_rv));
      chk("model_addr_err", 64'(addr_err), 64'(m_err));
      chk("model_busy", 64'(busy), 64'(m_left > 0));
      chk("model_block_full", 64'(block_full), 64'(exp_full));
      chk("model_block_data", block_data, exp_blk);
    end
  end

  task automatic cyc(input logic re, input logic we, input logic [15:0] a,
                     input logic [7:0] wd, input logic clr);
    read_enable = re; write_enable = we; address = a; write_data = wd; clear = clr;
    @(negedge clk);
    read_enable = 1'b0; write_enable = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int nbusy;
    #1 n_rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_read_data", 64'(read_data), 64'h0);
    chk("reset_block_data", block_data, 64'h0);
    chk("reset_busy_full", 64'({busy, block_full, read_valid, addr_err}), 64'h0);
    n_rst = 1'b1;
    @(negedge clk);

    // Write then read one word.
    cyc(0, 1, 16'h0003, 8'hA5, 0);
    chk("t1_block_word2", 64'(block_data[23:16]), 64'hA5);
    cyc(1, 0, 16'h0003, 8'h00, 0);
    chk("t1_read_data", 64'(read_data), 64'hA5);
    chk("t1_read_valid", 64'(read_valid), 64'h1);
    cyc(0, 0, 16'h0000, 8'h00, 0);
    chk("t1_read_valid_drop", 64'(read_valid), 64'h0);

    // Fill every word.
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == DEPTH) chk("t2_not_full_yet", 64'(block_full), 64'h0);
      cyc(0, 1, 16'(i), 8'(8'h11 * i), 0);
    end
    chk("t2_block_full", 64'(block_full), 64'h1);
    chk("t2_block_data", block_data, 64'h8877665544332211);

    // Out-of-range requests below and above the window.
    cyc(1, 0, 16'h0000, 8'h00, 0);
    chk("t3_err_low", 64'(addr_err), 64'h1);
    chk("t3_no_rv_low", 64'(read_valid), 64'h0);
    cyc(0, 1, 16'h0009, 8'hFF, 0);
    chk("t3_err_high", 64'(addr_err), 64'h1);
    cyc(0, 0, 16'h0000, 8'h00, 0);
    chk("t3_err_clear", 64'(addr_err), 64'h0);
    chk("t3_mem_kept", block_data, 64'h8877665544332211);

    // Clear sweep, with a write attempted mid-sweep.
    cyc(0, 0, 16'h0000, 8'h00, 1);
    nbusy = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy) nbusy++;
      if (c == 2) cyc(0, 1, 16'h0005, 8'h77, 0);
      else cyc(0, 0, 16'h0000, 8'h00, 0);
    end
    chk("t4_busy_cycles", 64'(nbusy), 64'd8);
    chk("t4_block_zero", block_data, 64'h0);
    chk("t4_not_full", 64'(block_full), 64'h0);
    cyc(1, 0, 16'h0005, 8'h00, 0);
    chk("t4_read_zero", 64'(read_data), 64'h0);
    chk("t4_read_valid", 64'(read_valid), 64'h1);

    // Same-cycle read and write of one address.
    cyc(0, 1, 16'h0004, 8'h3C, 0);
    cyc(1, 1, 16'h0004, 8'hC3, 0);
    chk("t5_rw_same", 64'(read_data), BYP ? 64'hC3 : 64'h3C);
    cyc(1, 0, 16'h0004, 8'h00, 0);
    chk("t5_after_write", 64'(read_data), 64'hC3);

    // Reset in the middle of a sweep.
    cyc(0, 0, 16'h0000, 8'h00, 1);
    repeat (3) cyc(0, 0, 16'h0000, 8'h00, 0);
    chk("t6_busy_mid", 64'(busy), 64'h1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_rst_outputs", 64'({busy, block_full, read_valid, addr_err}), 64'h0);
    chk("t6_rst_data", 64'(read_data) | block_data, 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    cyc(0, 1, 16'h0002, 8'h5A, 0);
    cyc(1, 0, 16'h0002, 8'h00, 0);
    chk("t6_read_after", 64'(read_data), 64'h5A);
    chk("t6_rv_after", 64'(read_valid), 64'h1);
    chk("t6_block_word1", 64'(block_data[15:8]), 64'h5A);
    cyc(0, 0, 16'h0000, 8'h00, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
